acc_feeder: RTL
===============

# acc_feeder

Stream source and result collector for the accumulator core. On a start command it emits a programmable arithmetic sequence of IN_DATA_WIDTH-bit words with valid/run qualifiers into the accumulator's input port. It then waits for the accumulator's valid output, captures the DWIDTH-bit result, and signals completion. It sits between the control/register layer and the accumulator core and replaces hand-written stimulus at system level.

## Interface
- IN_DATA_WIDTH, 8, width of each emitted word.
- DWIDTH, 16, width of accumulated result.
- CNT_WIDTH, 8, width of sequence-length counter.
- TIMEOUT, 16, max DRAIN cycles waiting for acc_valid_i.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  start command; sampled in IDLE only.
- len_i  in  CNT_WIDTH  number of words to emit; latched on start.
- base_i  in  IN_DATA_WIDTH  first word; latched on start.
- step_i  in  IN_DATA_WIDTH  increment between words; latched on start.
- hold_i  in  1  stall; freezes emission while high.
- acc_valid_i  in  1  accumulator result valid.
- acc_result_i  in  DWIDTH  accumulator result.
- number_o  out  IN_DATA_WIDTH  emitted word (to accumulator number input).
- valid_o  out  1  number_o valid (to accumulator valid input).
- run_o  out  1  run qualifier (to accumulator run input).
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  sticky until next start; DRAIN expired.
- result_o  out  DWIDTH  captured accumulator result.

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_i=1 with len_i!=0 -> latch len/base/step, clear timeout_o, go RUN. start_i with len_i=0 is ignored. start_i in any other state is ignored.
- RUN: run_o=1. Each cycle with hold_i=0: valid_o=1, number_o = base + k*step mod 2^IN_DATA_WIDTH, where k = 0..len-1, and k increments. With hold_i=1: valid_o=0, number_o holds, k frozen. After word len-1 is emitted, go DRAIN.
- DRAIN: valid_o=0, run_o=1, number_o holds its last value. The first acc_valid_i=1 -> result_o <= acc_result_i, go DONE. If TIMEOUT cycles pass with no acc_valid_i -> timeout_o=1, result_o unchanged, go DONE.
- DONE: done_o=1 for exactly one cycle, run_o=0, then IDLE.
- acc_valid_i in IDLE/RUN/DONE is ignored.
- Word wrap: the arithmetic wraps modulo 2^IN_DATA_WIDTH with no saturation.

## Timing
- All outputs are registered.
- Start sampled on edge N -> busy_o and first valid_o/number_o visible after edge N+1.
- With no hold, len words occupy len consecutive cycles. valid_o falls the cycle after the last word.
- hold_i sampled on edge: a hold high at edge M suppresses the word that would appear after M.
- acc_valid_i at DRAIN edge D -> result_o updated and done_o high after D+1. done_o low after D+2, and busy_o low with it.
- Timeout: DRAIN cycle count reaches TIMEOUT -> DONE on the next edge.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. No done_o pulse.
- Simultaneous hold_i and last word: the word is withheld; the transition to DRAIN occurs only after it is emitted.

## Configuration
- ACC_FEEDER_CHECK_EN defined:
  - Adds a DWIDTH-bit expected-sum register, cleared on start, which adds each emitted word zero-extended, modulo 2^DWIDTH.
  - Adds output mismatch_o (1 bit, reset 0). It is set with done_o when a captured result != expected, and held until the next start.
  - No mismatch is flagged on timeout.
- Undefined: no expected-sum logic and no mismatch_o port. All other behaviour is identical.

## Test plan
- Reset, then start with base=2, step=1, len=70, no hold -> words 2..71 on 70 consecutive valid_o cycles, run_o high throughout. Drive acc_valid_i with 2555 -> result_o=2555, one done_o pulse, mismatch_o=0.
- base=250, step=3, len=4 -> number_o = 250, 253, 0, 3 (wrap). Expected sum 506.
- len=5, hold_i high on cycles 2–3 of RUN -> exactly 5 valid words, 2-cycle gap, values unchanged across the gap.
- Sequence complete and acc_valid_i never asserted -> timeout_o=1 after TIMEOUT DRAIN cycles, done_o pulse, result_o keeps its previous value.
- Reset asserted at word 10 of 20 -> all outputs 0 immediately, no done_o. A new start then runs a clean sequence.
- With check enabled: return acc_result_i=2554 for the first case -> mismatch_o=1 with done_o. start_i with len_i=0 -> busy_o stays 0.

Source files
------------

// File: rtl/acc_feeder_if.sv
// rtl/acc_feeder_if.sv - command, word stream and result signals of acc_feeder
// mismatch_o exists only when ACC_FEEDER_CHECK_EN is defined.
interface acc_feeder_if #(
   parameter int IN_DATA_WIDTH = 8,
   parameter int DWIDTH        = 16,
   parameter int CNT_WIDTH     = 8
);
   logic                     start_i;
   logic [CNT_WIDTH-1:0]     len_i;
   logic [IN_DATA_WIDTH-1:0] base_i;
   logic [IN_DATA_WIDTH-1:0] step_i;
   logic                     hold_i;
   logic                     acc_valid_i;
   logic [DWIDTH-1:0]        acc_result_i;
   logic [IN_DATA_WIDTH-1:0] number_o;
   logic                     valid_o;
   logic                     run_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     timeout_o;
   logic [DWIDTH-1:0]        result_o;
`ifdef ACC_FEEDER_CHECK_EN
   logic                     mismatch_o;
`endif

   modport slave (
`ifdef ACC_FEEDER_CHECK_EN
      output mismatch_o,
`endif
      input  start_i, len_i, base_i, step_i, hold_i, acc_valid_i, acc_result_i,
      output number_o, valid_o, run_o, busy_o, done_o, timeout_o, result_o
   );

   modport master (
`ifdef ACC_FEEDER_CHECK_EN
      input  mismatch_o,
`endif
      output start_i, len_i, base_i, step_i, hold_i, acc_valid_i, acc_result_i,
      input  number_o, valid_o, run_o, busy_o, done_o, timeout_o, result_o
   );
endinterface

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - arithmetic word source and result collector for the accumulator core
// ACC_FEEDER_CHECK_EN adds an expected-sum register and the mismatch_o flag.
module acc_feeder #(
   parameter int IN_DATA_WIDTH = 8,
   parameter int DWIDTH        = 16,
   parameter int CNT_WIDTH     = 8,
   parameter int TIMEOUT       = 16
) (
   input logic        clk,
   input logic        reset,
   acc_feeder_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state, state_n;
   logic [CNT_WIDTH-1:0]     len_q, len_n, k_q, k_n;
   logic [IN_DATA_WIDTH-1:0] step_q, step_n, nw_q, nw_n;
   logic [TW-1:0]            drain_q, drain_n;
   logic [DWIDTH-1:0]        cap_q, cap_n;
   logic                     to_q, to_n;
   logic [IN_DATA_WIDTH-1:0] number_q, number_n;
   logic                     valid_q, valid_n, run_q, run_n, busy_q, busy_n;
   logic                     done_q, done_n, timeout_q, timeout_n;
   logic [DWIDTH-1:0]        result_q, result_n;
`ifdef ACC_FEEDER_CHECK_EN
   logic [DWIDTH-1:0]        exp_q, exp_n;
   logic                     mismatch_q, mismatch_n;
`endif

   // Every output is a register loaded from the *_n values, so outputs trail the state by one edge.
   always_comb begin
      state_n   = state;
      len_n     = len_q;
      k_n       = k_q;
      step_n    = step_q;
      nw_n      = nw_q;
      drain_n   = drain_q;
      cap_n     = cap_q;
      to_n      = to_q;
      number_n  = number_q;
      valid_n   = 1'b0;
      run_n     = 1'b0;
      busy_n    = (state != IDLE);
      done_n    = 1'b0;
      timeout_n = timeout_q;
      result_n  = result_q;
`ifdef ACC_FEEDER_CHECK_EN
      exp_n      = exp_q;
      mismatch_n = mismatch_q;
`endif
      case (state)
         IDLE: begin
            if (bus.start_i && (bus.len_i != '0)) begin
               state_n   = RUN;
               len_n     = bus.len_i;
               step_n    = bus.step_i;
               nw_n      = bus.base_i;
               k_n       = '0;
               drain_n   = '0;
               to_n      = 1'b0;
               timeout_n = 1'b0;
`ifdef ACC_FEEDER_CHECK_EN
               exp_n      = '0;
               mismatch_n = 1'b0;
`endif
            end
         end
         RUN: begin
            run_n = 1'b1;
            if (!bus.hold_i) begin
               valid_n  = 1'b1;
               number_n = nw_q;
               nw_n     = nw_q + step_q;
               k_n      = k_q + CNT_WIDTH'(1);
`ifdef ACC_FEEDER_CHECK_EN
               exp_n    = exp_q + DWIDTH'(nw_q);
`endif
               if (k_q == len_q - CNT_WIDTH'(1))
                  state_n = DRAIN;
            end
         end
         DRAIN: begin
            run_n = 1'b1;
            if (bus.acc_valid_i) begin
               cap_n   = bus.acc_result_i;
               state_n = DONE;
            end else if (drain_q == TW'(TIMEOUT - 1)) begin
               to_n    = 1'b1;
               state_n = DONE;
            end else begin
               drain_n = drain_q + TW'(1);
            end
         end
         DONE: begin
            done_n  = 1'b1;
            state_n = IDLE;
            if (to_q) begin
               timeout_n = 1'b1;
            end else begin
               result_n = cap_q;
`ifdef ACC_FEEDER_CHECK_EN
               if (cap_q != exp_q)
                  mismatch_n = 1'b1;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         k_q       <= '0;
         step_q    <= '0;
         nw_q      <= '0;
         drain_q   <= '0;
         cap_q     <= '0;
         to_q      <= 1'b0;
         number_q  <= '0;
         valid_q   <= 1'b0;
         run_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         result_q  <= '0;
`ifdef ACC_FEEDER_CHECK_EN
         exp_q      <= '0;
         mismatch_q <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         len_q     <= len_n;
         k_q       <= k_n;
         step_q    <= step_n;
         nw_q      <= nw_n;
         drain_q   <= drain_n;
         cap_q     <= cap_n;
         to_q      <= to_n;
         number_q  <= number_n;
         valid_q   <= valid_n;
         run_q     <= run_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
         timeout_q <= timeout_n;
         result_q  <= result_n;
`ifdef ACC_FEEDER_CHECK_EN
         exp_q      <= exp_n;
         mismatch_q <= mismatch_n;
`endif
      end
   end

   assign bus.number_o  = number_q;
   assign bus.valid_o   = valid_q;
   assign bus.run_o     = run_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.timeout_o = timeout_q;
   assign bus.result_o  = result_q;
`ifdef ACC_FEEDER_CHECK_EN
   assign bus.mismatch_o = mismatch_q;
`endif
endmodule
